// File: rtl/apb_mem_completer.sv
// APB completer backed by a word-addressed register memory.
// Programmable wait states; out-of-range addresses are answered with pslverr.
module apb_mem_completer #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
    localparam logic [3:0]    WS_L    = WAIT_STATES[3:0];

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q;
    logic [3:0]      wcnt_q;
    logic            err_q;
    logic [DW-1:0]   prdata_q;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [IW-1:0]   idx;
    logic            addr_err;
    logic            mem_we;

    // Full-width compare so upper address bits can never alias into the array.
    assign idx      = paddr[IW-1:0];
    assign addr_err = ({1'b0, paddr} >= DEPTH_L);

    assign pready   = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign pslverr  = pready && err_q;
    assign prdata   = prdata_q;
    assign mem_we   = pready && psel && penable && pwrite && !err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            wcnt_q   <= 4'd0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        wcnt_q  <= WS_L;
                        err_q   <= addr_err;
                        // Read data is fetched at setup so it is stable for the whole access phase.
                        if (!pwrite) begin
                            prdata_q <= addr_err ? '0 : mem_q[idx];
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (penable) begin
                        if (wcnt_q != 4'd0) begin
                            wcnt_q <= wcnt_q - 4'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= pwdata;
        end
    end

endmodule
